// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stage-register controls; the core drives master, the controller is slave.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_halt;
  logic             ex_mem_to_reg;
  logic [REG_W-1:0] ex_rt_dst;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic pc_en;
  logic ifid_en;
  logic ifid_flush;
  logic idex_en;
  logic idex_bubble;
  logic exmem_en;
  logic memwb_en;
  logic halted;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_halt, ex_mem_to_reg, ex_rt_dst,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           memwb_en, halted
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_halt, ex_mem_to_reg, ex_rt_dst,
           ex_branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           memwb_en, halted
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard: the load in ID/EX writes a nonzero register the ID instruction reads.
// Purely combinational, no latency, no backpressure of its own.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_to_reg,
  input  logic [REG_W-1:0] ex_rt_dst,
  output logic             load_use
);

  assign load_use = ex_mem_to_reg && (ex_rt_dst != REG_ZERO) &&
                    ((ex_rt_dst == id_rs) || (id_uses_rt && (ex_rt_dst == id_rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: Mealy stage enables/bubble/flush, memory stalls freeze every stage.
// PIPE_CTRL_PERF_EN adds saturating stall/bubble/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
)
(
  input  logic clk,
  input  logic rst_b,
  pipe_ctrl_if.slave bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pipe_state_t       state, state_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  logic              load_use;
  logic              mem_stall;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, halted;

  pipe_hazard_detect u_hazard (
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_uses_rt   (bus.id_uses_rt),
    .ex_mem_to_reg(bus.ex_mem_to_reg),
    .ex_rt_dst    (bus.ex_rt_dst),
    .load_use     (load_use)
  );

  assign mem_stall = bus.mem_req && !bus.mem_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dcnt_nxt    = dcnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    halted      = 1'b0;

    case (state)
      RUN, MEM_WAIT: begin
        // MEM_WAIT waits on mem_ready alone; on release it resolves like RUN.
        if ((state == RUN) ? mem_stall : !bus.mem_ready) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          state_nxt = MEM_WAIT;
        end else if (bus.ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_nxt   = RUN;
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          state_nxt   = RUN;
        end else if (bus.id_halt) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          dcnt_nxt  = DCNT_W'(DRAIN_CYCLES - 1);
          state_nxt = DRAIN;
        end else begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        if (mem_stall) begin
          {idex_en, exmem_en, memwb_en} = '0;
        end else if (dcnt == '0) begin
          state_nxt = HALTED;
        end else begin
          dcnt_nxt = dcnt - DCNT_W'(1);
        end
      end
      HALTED: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        halted = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    // Everything is held quiet while reset is asserted.
    if (!rst_b) begin
      {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, halted} = '0;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_bubble = idex_bubble;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.halted      = halted;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && (state != HALTED) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (idex_bubble && (bubble_count != '1))
        bubble_count <= bubble_count + CNT_W'(1);
      if (ifid_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule
